// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle main controller and the MIPS datapath.
//   opcode, mem_ready       : datapath -> controller (IR opcode field, memory done)
//   pc_write .. illegal     : controller -> datapath strobes and mux selects
//   state                   : controller -> observer, current FSM state
// Modports: master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_beq;
    logic                pc_write_bne;
    logic                i_or_d;
    logic                ir_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                reg_write2;
    logic                reg_dst;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                zero_ext;
    logic                lui;
    logic [ALUOP_W-1:0]  alu_op;
    logic [1:0]          pc_source;
    logic                illegal;
    logic [3:0]          state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_beq, pc_write_bne, i_or_d, ir_write, mem_read, mem_write,
               mem_to_reg, reg_write, reg_write2, reg_dst, alu_src_a, alu_src_b, zero_ext,
               lui, alu_op, pc_source, illegal, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_beq, pc_write_bne, i_or_d, ir_write, mem_read, mem_write,
               mem_to_reg, reg_write, reg_write2, reg_dst, alu_src_a, alu_src_b, zero_ext,
               lui, alu_op, pc_source, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM for the 32-bit MIPS core. Sequences each instruction through
// fetch/decode/execute/memory/writeback, stalls memory states on mem_ready and traps unknown
// opcodes with a one-cycle illegal pulse.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH
//   bus   : master side of multicycle_controller_if (opcode/mem_ready in, control out)
module multicycle_controller #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2,
    parameter bit          MEM_HS   = 1'b1
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OpR   = OPCODE_W'(6'b00_0000);
    localparam logic [OPCODE_W-1:0] OpLw  = OPCODE_W'(6'b10_0011);
    localparam logic [OPCODE_W-1:0] OpSw  = OPCODE_W'(6'b10_1011);
    localparam logic [OPCODE_W-1:0] OpBeq = OPCODE_W'(6'b00_0100);
    localparam logic [OPCODE_W-1:0] OpBne = OPCODE_W'(6'b00_0101);
    localparam logic [OPCODE_W-1:0] OpJ   = OPCODE_W'(6'b00_0010);
    localparam logic [OPCODE_W-1:0] OpJal = OPCODE_W'(6'b00_0011);
    localparam logic [OPCODE_W-1:0] OpOri = OPCODE_W'(6'b00_1101);
    localparam logic [OPCODE_W-1:0] OpLui = OPCODE_W'(6'b00_1111);

    state_e state_q, state_d;
    logic   mem_done;

    // Without the handshake every memory access completes in its first cycle.
    assign mem_done  = !MEM_HS || bus.mem_ready;
    assign bus.state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.pc_write     = 1'b0;
        bus.pc_write_beq = 1'b0;
        bus.pc_write_bne = 1'b0;
        bus.i_or_d       = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.reg_write    = 1'b0;
        bus.reg_write2   = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'b00;
        bus.zero_ext     = 1'b0;
        bus.lui          = 1'b0;
        bus.alu_op       = ALUOP_W'(2'b00);
        bus.pc_source    = 2'b00;
        bus.illegal      = 1'b0;

        case (state_q)
            StFetch: begin
                // Read stays asserted through the stall; IR/PC load only on completion.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                if (mem_done) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                // ALU precomputes the branch target while the opcode is decoded.
                bus.alu_src_b = 2'b11;
                if (bus.opcode == OpR) begin
                    state_d = StRExec;
                end else if (bus.opcode == OpLw || bus.opcode == OpSw) begin
                    state_d = StMemAddr;
                end else if (bus.opcode == OpBeq || bus.opcode == OpBne) begin
                    state_d = StBranch;
                end else if (bus.opcode == OpJ || bus.opcode == OpJal) begin
                    state_d = StJump;
                end else if (bus.opcode == OpOri || bus.opcode == OpLui) begin
                    state_d = StIExec;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = StFetch;
                end
            end
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (mem_done) state_d = StMemWb;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = StFetch;
            end
            StMemWr: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (mem_done) state_d = StFetch;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_W'(2'b10);
                state_d       = StRWb;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                bus.alu_src_a    = 1'b1;
                bus.alu_op       = ALUOP_W'(2'b01);
                bus.pc_source    = 2'b01;
                bus.pc_write_beq = (bus.opcode == OpBeq);
                bus.pc_write_bne = (bus.opcode == OpBne);
                state_d          = StFetch;
            end
            StJump: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.reg_write2 = (bus.opcode == OpJal);
                state_d        = StFetch;
            end
            StIExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.opcode == OpOri) begin
                    bus.alu_op   = ALUOP_W'(2'b11);
                    bus.zero_ext = 1'b1;
                end else begin
                    bus.lui = 1'b1;
                end
                state_d = StIWb;
            end
            StIWb: begin
                // Writeback mux still needs the ori/lui selection.
                bus.reg_write = 1'b1;
                bus.zero_ext  = (bus.opcode == OpOri);
                bus.lui       = (bus.opcode == OpLui);
                state_d       = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end
endmodule
